// File: rtl/mpadder_pkg.sv
// Shared types and constants for the mpadder command sequencer.
package mpadder_pkg;

    localparam int DEF_WIDTH    = 514;
    localparam int DEF_NCHUNK   = 5;
    localparam int DEF_SELW     = 4;
    localparam int SEL_IDLE     = 8;
    localparam int FLUSH_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_RESOLVE = 3'd2,
        ST_SUB     = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/mpadder_seq_if.sv
// Operand stream from the loop controller plus the command bus to mpadder.
// The master modport is the sequencer side; slave is the environment side.
interface mpadder_seq_if
    import mpadder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SELW  = DEF_SELW
);
    logic             op_valid;
    logic [WIDTH-1:0] op_data;
    logic             op_last;
    logic             op_ready;

    logic [WIDTH-1:0] add_in_a;
    logic             add_subtract;
    logic             add_shift;
    logic             add_enableC;
    logic [SELW-1:0]  add_sel;
    logic             add_czero;

    modport master (
        input  op_valid, op_data, op_last, add_czero,
        output op_ready, add_in_a, add_subtract, add_shift, add_enableC, add_sel
    );

    modport slave (
        output op_valid, op_data, op_last, add_czero,
        input  op_ready, add_in_a, add_subtract, add_shift, add_enableC, add_sel
    );

endinterface

// File: rtl/mpadder_seq_stepctr.sv
// Chunk-select counter (0..NCHUNK-1, also reused to count flush cycles)
// and a saturating 4-bit subtract-pass counter, both steered by the FSM.
module mpadder_seq_stepctr
    import mpadder_pkg::*;
#(
    parameter int NCHUNK = DEF_NCHUNK,
    parameter int SELW   = DEF_SELW
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_chunk_clr,
    input  logic            i_chunk_load,
    input  logic [SELW-1:0] i_chunk_val,
    input  logic            i_chunk_en,
    output logic [SELW-1:0] o_chunk,
    output logic            o_chunk_tc,
    input  logic            i_pass_clr,
    input  logic            i_pass_en,
    output logic [3:0]      o_pass
);

    localparam logic [SELW-1:0] LP_LAST = SELW'(NCHUNK - 1);

    logic [SELW-1:0] r_chunk;
    logic [3:0]      r_pass;

    // Chunk counter: clear beats load beats increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chunk <= '0;
        end else if (i_chunk_clr) begin
            r_chunk <= '0;
        end else if (i_chunk_load) begin
            r_chunk <= i_chunk_val;
        end else if (i_chunk_en) begin
            r_chunk <= r_chunk + 1'b1;
        end
    end

    // Pass counter saturates at 15 so max_pass=15 never sees a wrap to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pass <= '0;
        end else if (i_pass_clr) begin
            r_pass <= '0;
        end else if (i_pass_en && (r_pass != 4'hF)) begin
            r_pass <= r_pass + 1'b1;
        end
    end

    assign o_chunk    = r_chunk;
    assign o_chunk_tc = (r_chunk == LP_LAST);
    assign o_pass     = r_pass;

endmodule

// File: rtl/mpadder_seq.sv
// Command sequencer for mpadder: operand accumulate, carry-resolve sweep,
// conditional modulus-subtract passes, flush, done.
//
// The state names the command scheduled for the NEXT clock edge; every
// adder output is registered, so a command chosen at edge k is visible
// during cycle k+1.
//
// state   | meaning
// IDLE    | waiting for start; adder outputs idle
// ACCUM   | op_ready=1; each handshake registers one add command
// RESOLVE | issue sel=0..NCHUNK-1 carry sweep
// SUB     | issue subtract passes; at chunk 0 after a pass, check czero/limit
// FLUSH   | issue idle commands until FLUSH_CYCLES have been emitted
// DONE    | register the done pulse and final overflow
module mpadder_seq
    import mpadder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NCHUNK = DEF_NCHUNK,
    parameter int SELW   = DEF_SELW
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       max_pass,
    input  logic [WIDTH-1:0] sub_data,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    mpadder_seq_if.master    bus
);

    localparam logic [SELW-1:0] LP_SEL_IDLE   = SELW'(SEL_IDLE);
    localparam logic [SELW-1:0] LP_FLUSH_LAST = SELW'(FLUSH_CYCLES - 1);

    seq_state_t       r_state;
    logic             r_op_ready;
    logic [WIDTH-1:0] r_in_a;
    logic             r_subtract;
    logic             r_shift;
    logic             r_enablec;
    logic [SELW-1:0]  r_sel;
    logic             r_busy;
    logic             r_done;
    logic             r_overflow;
    logic             r_ovf_pend;
    logic [3:0]       r_max_pass;

    seq_state_t       w_state_nxt;
    logic             w_op_ready_nxt;
    logic [WIDTH-1:0] w_in_a_nxt;
    logic             w_subtract_nxt;
    logic             w_shift_nxt;
    logic             w_enablec_nxt;
    logic [SELW-1:0]  w_sel_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_overflow_nxt;
    logic             w_ovf_pend_nxt;
    logic             w_max_pass_ld;

    logic             w_chunk_clr;
    logic             w_chunk_load;
    logic [SELW-1:0]  w_chunk_val;
    logic             w_chunk_en;
    logic [SELW-1:0]  w_chunk;
    logic             w_chunk_tc;
    logic             w_pass_clr;
    logic             w_pass_en;
    logic [3:0]       w_pass;

    logic             w_accept;
    logic             w_pass_end;

    assign w_accept   = r_op_ready & bus.op_valid;
    // Chunk 0 with a nonzero pass count means a pass just finished and the
    // adder's carry-zero flag for that pass is on the input this cycle.
    assign w_pass_end = (w_chunk == '0) && (w_pass != 4'd0);

    mpadder_seq_stepctr #(
        .NCHUNK (NCHUNK),
        .SELW   (SELW)
    ) u_stepctr (
        .clk          (clk),
        .reset        (reset),
        .i_chunk_clr  (w_chunk_clr),
        .i_chunk_load (w_chunk_load),
        .i_chunk_val  (w_chunk_val),
        .i_chunk_en   (w_chunk_en),
        .o_chunk      (w_chunk),
        .o_chunk_tc   (w_chunk_tc),
        .i_pass_clr   (w_pass_clr),
        .i_pass_en    (w_pass_en),
        .o_pass       (w_pass)
    );

    // Next state, next registered outputs and counter controls.
    always_comb begin
        w_state_nxt    = r_state;
        w_op_ready_nxt = r_op_ready;
        w_in_a_nxt     = '0;
        w_subtract_nxt = 1'b0;
        w_shift_nxt    = 1'b0;
        w_enablec_nxt  = 1'b0;
        w_sel_nxt      = LP_SEL_IDLE;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_overflow_nxt = r_overflow;
        w_ovf_pend_nxt = r_ovf_pend;
        w_max_pass_ld  = 1'b0;
        w_chunk_clr    = 1'b0;
        w_chunk_load   = 1'b0;
        w_chunk_val    = '0;
        w_chunk_en     = 1'b0;
        w_pass_clr     = 1'b0;
        w_pass_en      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt    = ST_ACCUM;
                    w_op_ready_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_overflow_nxt = 1'b0;
                    w_ovf_pend_nxt = 1'b0;
                    w_max_pass_ld  = 1'b1;
                    w_chunk_clr    = 1'b1;
                    w_pass_clr     = 1'b1;
                end
            end

            ST_ACCUM: begin
                if (w_accept) begin
                    w_in_a_nxt    = bus.op_data;
                    w_enablec_nxt = 1'b1;
                    w_shift_nxt   = bus.op_last;
                    if (bus.op_last) begin
                        w_state_nxt    = ST_RESOLVE;
                        w_op_ready_nxt = 1'b0;
                        w_chunk_clr    = 1'b1;
                    end
                end
            end

            ST_RESOLVE: begin
                w_sel_nxt = w_chunk;
                if (w_chunk_tc) begin
                    w_chunk_clr = 1'b1;
                    w_pass_clr  = 1'b1;
                    w_state_nxt = (r_max_pass == 4'd0) ? ST_FLUSH : ST_SUB;
                end else begin
                    w_chunk_en = 1'b1;
                end
            end

            ST_SUB: begin
                if (w_pass_end && (bus.add_czero || (w_pass == r_max_pass))) begin
                    // This edge already emits the first flush cycle.
                    w_state_nxt    = ST_FLUSH;
                    w_ovf_pend_nxt = ~bus.add_czero;
                    w_chunk_load   = 1'b1;
                    w_chunk_val    = SELW'(1);
                end else begin
                    w_sel_nxt      = w_chunk;
                    w_subtract_nxt = 1'b1;
                    w_in_a_nxt     = sub_data;
                    if (w_chunk_tc) begin
                        w_chunk_clr = 1'b1;
                        w_pass_en   = 1'b1;
                    end else begin
                        w_chunk_en = 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                if (w_chunk == LP_FLUSH_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_chunk_en = 1'b1;
                end
            end

            ST_DONE: begin
                w_done_nxt     = 1'b1;
                w_overflow_nxt = r_ovf_pend;
                w_state_nxt    = ST_IDLE;
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_op_ready_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    // State, registered outputs and the latched pass limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op_ready <= 1'b0;
            r_in_a     <= '0;
            r_subtract <= 1'b0;
            r_shift    <= 1'b0;
            r_enablec  <= 1'b0;
            r_sel      <= LP_SEL_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_max_pass <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_op_ready <= w_op_ready_nxt;
            r_in_a     <= w_in_a_nxt;
            r_subtract <= w_subtract_nxt;
            r_shift    <= w_shift_nxt;
            r_enablec  <= w_enablec_nxt;
            r_sel      <= w_sel_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_overflow <= w_overflow_nxt;
            r_ovf_pend <= w_ovf_pend_nxt;
            if (w_max_pass_ld) begin
                r_max_pass <= max_pass;
            end
        end
    end

    assign bus.op_ready     = r_op_ready;
    assign bus.add_in_a     = r_in_a;
    assign bus.add_subtract = r_subtract;
    assign bus.add_shift    = r_shift;
    assign bus.add_enableC  = r_enablec;
    assign bus.add_sel      = r_sel;
    assign busy             = r_busy;
    assign done             = r_done;
    assign overflow         = r_overflow;

endmodule

// File: tb/tb_mpadder_seq.sv
// Scoreboard bench for mpadder_seq: each job's full expected command
// stream is computed from the job parameters and queued; a monitor pops
// one entry per busy cycle and compares.
module tb_mpadder_seq;

    localparam int W  = 514;
    localparam int NC = 5;

    typedef struct {
        logic [W-1:0] in_a;
        logic         sub;
        logic         shift;
        logic         en;
        logic [3:0]   sel;
        logic         ready;
        logic         done;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   max_pass;
    logic [W-1:0] sub_data;
    logic         busy, done, overflow;

    mpadder_seq_if #(.WIDTH(W), .SELW(4)) bus();

    mpadder_seq #(.WIDTH(W), .NCHUNK(NC), .SELW(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .max_pass (max_pass),
        .sub_data (sub_data),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           g_gaps[8];
    logic [W-1:0] g_data[8];
    int           czero_target = 0;
    logic         g_exp_ovf;

    function automatic logic [W-1:0] rnd_wide();
        logic [W-1:0] v = '0;
        for (int k = 0; k < 17; k++) v = {v[W-33:0], $urandom()};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_e(input logic [W-1:0] a, input logic s, input logic sh, input logic e,
                          input logic [3:0] sel, input logic rdy, input logic d, input logic ov);
        exp_t x;
        x.in_a = a; x.sub = s; x.shift = sh; x.en = e; x.sel = sel;
        x.ready = rdy; x.done = d; x.ovf = ov;
        q.push_back(x);
    endtask

    // Reference model: expected per-cycle command stream for one job.
    task automatic build_expect(input int nops, input logic [3:0] mp, input int target);
        int passes;
        push_e('0, 0, 0, 0, 4'd8, 1, 0, 0);
        for (int i = 0; i < nops; i++) begin
            for (int g = 0; g < g_gaps[i]; g++) push_e('0, 0, 0, 0, 4'd8, 1, 0, 0);
            push_e(g_data[i], 0, (i == nops - 1), 1, 4'd8, (i != nops - 1), 0, 0);
        end
        for (int c = 0; c < NC; c++) push_e('0, 0, 0, 0, 4'(c), 0, 0, 0);
        if (mp == 0) begin
            passes = 0; g_exp_ovf = 0;
        end else if (target >= 1 && target <= int'(mp)) begin
            passes = target; g_exp_ovf = 0;
        end else begin
            passes = int'(mp); g_exp_ovf = 1;
        end
        for (int p = 0; p < passes; p++)
            for (int c = 0; c < NC; c++) push_e(sub_data, 1, 0, 0, 4'(c), 0, 0, 0);
        push_e('0, 0, 0, 0, 4'd8, 0, 0, 0);
        push_e('0, 0, 0, 0, 4'd8, 0, 0, 0);
        push_e('0, 0, 0, 0, 4'd8, 0, 1, g_exp_ovf);
    endtask

    task automatic start_and_ops(input int nops, input logic [3:0] mp);
        @(posedge clk); #1;
        start = 1; max_pass = mp;
        @(posedge clk); #1;
        start = 0; max_pass = 4'($urandom());
        for (int i = 0; i < nops; i++) begin
            for (int g = 0; g < g_gaps[i]; g++) begin
                bus.op_valid = 0; bus.op_data = rnd_wide(); bus.op_last = 1'($urandom());
                @(posedge clk); #1;
            end
            bus.op_valid = 1; bus.op_data = g_data[i]; bus.op_last = (i == nops - 1);
            @(posedge clk); #1;
        end
        // Outside ACCUM these must be ignored.
        bus.op_valid = 1; bus.op_last = 1; bus.op_data = rnd_wide();
    endtask

    task automatic run_job(input int nops, input logic [3:0] mp, input int target, input bit pulse);
        bit seen = 0;
        sub_data = rnd_wide();
        czero_target = target;
        build_expect(nops, mp, target);
        start_and_ops(nops, mp);
        if (pulse) begin
            start = 1; @(posedge clk); #1; start = 0;
        end
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: done not seen, expected within 400 cycles");
        end
        @(posedge clk); #1;
        bus.op_valid = 0; bus.op_last = 0;
        chk("queue_drained", 32'(q.size()), 32'd0);
        q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("ovf_held", overflow, g_exp_ovf);
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
        end
    endtask

    task automatic set_ops(input int nops, input int maxgap);
        for (int i = 0; i < 8; i++) begin
            g_gaps[i] = (i == 0) ? 0 : int'($urandom_range(maxgap, 0));
            g_data[i] = rnd_wide();
        end
        if (nops < 1) g_gaps[0] = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_op_ready"}, bus.op_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_overflow"}, overflow, 1'b0);
        chk({tag, "_in_a"}, bus.add_in_a, '0);
        chk({tag, "_sub_shift_en"}, {bus.add_subtract, bus.add_shift, bus.add_enableC}, 3'b000);
        chk({tag, "_sel"}, bus.add_sel, 4'd8);
    endtask

    // Adder stand-in: carry-zero reported at the end of pass czero_target,
    // random noise on every other cycle.
    int pass_seen = 0;
    initial begin
        bus.add_czero = 0;
        forever begin
            @(negedge clk);
            if (busy !== 1'b1) pass_seen = 0;
            if (bus.add_subtract === 1'b1 && bus.add_sel === 4'(NC - 1)) begin
                pass_seen++;
                bus.add_czero = (pass_seen == czero_target);
            end else begin
                bus.add_czero = 1'($urandom());
            end
        end
    end

    // Monitor: one expected entry per busy cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL mon_underrun: busy cycle with no expected entry (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("in_a", bus.add_in_a, e.in_a);
                    chk("subtract", bus.add_subtract, e.sub);
                    chk("shift", bus.add_shift, e.shift);
                    chk("enableC", bus.add_enableC, e.en);
                    chk("sel", bus.add_sel, e.sel);
                    chk("op_ready", bus.op_ready, e.ready);
                    chk("done", done, e.done);
                    chk("overflow", overflow, e.ovf);
                end
            end
        end
    end

    initial begin
        bit seen;
        reset = 1; start = 0; max_pass = 0; sub_data = '0;
        bus.op_valid = 0; bus.op_data = '0; bus.op_last = 0;
        #3;
        chk_reset_vals("por");
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Nominal: 3,3,X; czero after pass 1.
        set_ops(3, 0);
        g_data[0] = W'(3); g_data[1] = W'(3);
        run_job(3, 4'd4, 1, 0);

        // Pass limit reached.
        set_ops(2, 0);
        run_job(2, 4'd4, 0, 0);

        // Two-cycle bubble between operands.
        set_ops(3, 0);
        g_gaps[1] = 2;
        run_job(3, 4'd2, 2, 0);

        // Zero passes, single operand.
        set_ops(1, 0);
        run_job(1, 4'd0, 1, 0);

        // Start pulsed during RESOLVE.
        set_ops(2, 0);
        run_job(2, 4'd3, 2, 1);

        // Maximum pass count without carry-zero.
        set_ops(1, 0);
        run_job(1, 4'd15, 0, 0);

        // Reset in the middle of SUB.
        set_ops(2, 1);
        sub_data = rnd_wide();
        czero_target = 0;
        build_expect(2, 4'd15, 0);
        start_and_ops(2, 4'd15);
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (bus.add_subtract === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL sub_timeout: subtract not seen, expected within 200 cycles");
        end
        @(posedge clk); #1;
        reset = 1;
        #1;
        chk_reset_vals("mid_rst");
        q.delete();
        bus.op_valid = 0; bus.op_last = 0;
        @(posedge clk); #1;
        reset = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_ready", bus.op_ready, 1'b0);
            chk("post_rst_sel", bus.add_sel, 4'd8);
        end

        // Randomised jobs.
        for (int j = 0; j < 10; j++) begin
            int nops;
            nops = int'($urandom_range(4, 1));
            set_ops(nops, 2);
            run_job(nops, 4'($urandom_range(5, 0)), int'($urandom_range(6, 0)), 1'($urandom()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mpadder_seq.md
# mpadder_seq

Command sequencer that drives the multi-precision adder (`mpadder`) in the Montgomery datapath, replacing the hand-written stimulus sequence the adder is currently exercised with. It accepts a stream of operands through a valid/ready handshake and issues the accumulate/shift commands. It then runs the carry-resolve sweep and the conditional modulus-subtract passes, terminating on the adder's carry-zero flag. Sits between the Montgomery loop controller (upstream) and `mpadder` (downstream).

## Interface
- `WIDTH`, 514: operand width in bits.
- `NCHUNK`, 5: number of chunk-select steps per sweep or pass (`add_sel` = 0..NCHUNK-1).
- `SELW`, 4: width of `add_sel`.
- `clk` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a job; honoured only in IDLE.
- `max_pass` in 4: maximum number of subtract passes, sampled on accepted `start`.
- `sub_data` in WIDTH: two's-complement negated modulus (~M+1); held stable for the whole job.
- `op_valid` in 1: upstream operand valid.
- `op_data` in WIDTH: operand value.
- `op_last` in 1: marks the final operand, which is issued with shift.
- `op_ready` out 1: operand accepted when `op_valid & op_ready`.
- `add_in_a` out WIDTH: adder operand.
- `add_subtract` out 1: adder subtract mode.
- `add_shift` out 1: adder shift-after-add.
- `add_enableC` out 1: adder accumulate enable.
- `add_sel` out SELW: adder chunk select; 8 = idle/no-op.
- `add_czero` in 1: adder carry-zero flag.
- `busy` out 1: high from the cycle after accepted `start` until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse at job end.
- `overflow` out 1: set with `done` when the pass limit was hit without `add_czero`; held until the next `start`.

## Operation
- FSM states: IDLE, ACCUM, RESOLVE, SUB, FLUSH, DONE.
- **IDLE**
  - `op_ready`=0.
  - Adder outputs are idle: `in_a`=0, `subtract`/`shift`/`enableC`=0, `sel`=8.
  - `start` → ACCUM; clear `overflow`; latch `max_pass`.
- **ACCUM**
  - `op_ready`=1.
  - Each accepted operand produces one command cycle: `in_a`=`op_data`, `enableC`=1, `shift`=`op_last`, `subtract`=0, `sel`=8.
  - A cycle with no accepted operand produces idle adder outputs (a bubble).
  - Accepting `op_last` → RESOLVE and drops `op_ready` immediately.
  - A single-operand job with `op_last`=1 is legal.
- **RESOLVE**
  - NCHUNK cycles with `sel`=0..NCHUNK-1.
  - `enableC`=0, `subtract`=0, `in_a`=0.
  - Then → SUB, or → FLUSH directly if the latched `max_pass`=0.
- **SUB**
  - Each pass is NCHUNK cycles with `subtract`=1, `in_a`=`sub_data`, `sel`=0..NCHUNK-1.
  - `add_czero` is sampled at the clock edge ending the `sel`=NCHUNK-1 cycle.
  - `add_czero`=1 → FLUSH.
  - Otherwise, if the pass count equals `max_pass` → FLUSH with `overflow`=1; else start the next pass.
- **FLUSH**: 2 idle command cycles, then → DONE.
- **DONE**: `done`=1 for one cycle, then → IDLE.
- `start` outside IDLE is ignored. `op_valid` outside ACCUM is ignored.
- Pass counter is 4 bits and does not wrap; `max_pass`=15 gives up to 15 passes.

## Timing
- All outputs are registered. A handshake at edge k produces its command during cycle k+1.
- Command cycles are contiguous: last add command, then RESOLVE `sel`=0 in the very next cycle, then SUB, then FLUSH with no gaps.
- `done` follows the second FLUSH cycle.
- Job length is Nop + bubbles + NCHUNK·(1+P) + 2 command cycles, then `done`, where P is the number of passes run.
- **Reset values** (asynchronous, immediate, including mid-job):
  - state IDLE;
  - `op_ready`=0, `busy`=0, `done`=0, `overflow`=0;
  - `add_in_a`=0, `add_subtract`=0, `add_shift`=0, `add_enableC`=0, `add_sel`=8.
- No partial job resumes after reset.

## Structure
- Package `mpadder_pkg` holds:
  - the FSM state enum;
  - `SEL_IDLE`=8;
  - default `WIDTH`/`NCHUNK`/`SELW`;
  - `FLUSH_CYCLES`=2.
- One sub-module, `mpadder_seq_stepctr`:
  - chunk counter 0..NCHUNK-1 with a terminal-count flag, plus a pass counter;
  - load/clear/enable controlled by the FSM.
- The FSM and output registers live in `mpadder_seq`.

## Test plan
- **Reset mid-job:** assert `reset` during SUB → same cycle, all outputs at reset values; after release, state IDLE and `busy`=0.
- **Nominal job:** 3 back-to-back operands (3, 3, X with `op_last`), `max_pass`=4, `add_czero`=1 at the end of pass 1.
  - Cycles 1-3: `enableC`=1; `shift`=1 only in cycle 3.
  - Cycles 4-8: `sel`=0..4 with `subtract`=0.
  - Cycles 9-13: `sel`=0..4 with `subtract`=1 and `in_a`=`sub_data`.
  - Cycles 14-15: idle.
  - `done` in cycle 16, `overflow`=0.
- **Pass limit:** `add_czero` held 0, `max_pass`=4 → 20 subtract cycles, then `done` with `overflow`=1; `overflow` stays 1 until the next `start`.
- **Bubble:** `op_valid` low for 2 cycles between operands → 2 idle command cycles inserted; total job length grows by exactly 2.
- **Zero passes:** `max_pass`=0, single operand with `op_last` → 1 add, 5 resolve, 2 flush, `done` in cycle 9; `subtract` never asserted.
- **Ignored input:** `start` pulsed during RESOLVE → ignored; sequence and `done` timing unchanged.
